zjh_bcd_counter_disp: RTL and testbench

ZJH_BCD_COUNTER_DISP -- requirements
Module: zjh_bcd_counter_disp

---
 rtl/zjh_seg_pkg.sv | 23 ++
 rtl/zjh_seg7_dec.sv | 32 +++
 rtl/zjh_bcd_counter_disp.sv | 159 +++++++++++++++
 tb/tb_zjh_bcd_counter_disp.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/zjh_seg_pkg.sv
// Shared constants for the BCD counter/display: MODE encodings and
// 7-segment patterns (SEG[6]=a .. SEG[0]=g, active-high).
package zjh_seg_pkg;

   typedef logic [6:0] seg_t;

   localparam logic [1:0] MODE_FREE   = 2'b00;
   localparam logic [1:0] MODE_RELOAD = 2'b01;
   localparam logic [1:0] MODE_STOP   = 2'b10;

   localparam seg_t SEG_0     = 7'h7E;
   localparam seg_t SEG_1     = 7'h30;
   localparam seg_t SEG_2     = 7'h6D;
   localparam seg_t SEG_3     = 7'h79;
   localparam seg_t SEG_4     = 7'h33;
   localparam seg_t SEG_5     = 7'h5B;
   localparam seg_t SEG_6     = 7'h5F;
   localparam seg_t SEG_7     = 7'h70;
   localparam seg_t SEG_8     = 7'h7F;
   localparam seg_t SEG_9     = 7'h7B;
   localparam seg_t SEG_BLANK = 7'h00;

endpackage

// File: rtl/zjh_seg7_dec.sv
// Combinational BCD to 7-segment decoder with blanking.
//   bcd   : 4-bit digit (10..15 decode to blank)
//   blank : force all segments off
//   seg_c : segment pattern, SEG[6]=a .. SEG[0]=g
module zjh_seg7_dec
   import zjh_seg_pkg::*;
(
   input  logic [3:0] bcd,
   input  logic       blank,
   output seg_t       seg_c
);

   always_comb begin
      seg_c = SEG_BLANK;
      if (!blank) begin
         case (bcd)
            4'd0:    seg_c = SEG_0;
            4'd1:    seg_c = SEG_1;
            4'd2:    seg_c = SEG_2;
            4'd3:    seg_c = SEG_3;
            4'd4:    seg_c = SEG_4;
            4'd5:    seg_c = SEG_5;
            4'd6:    seg_c = SEG_6;
            4'd7:    seg_c = SEG_7;
            4'd8:    seg_c = SEG_8;
            4'd9:    seg_c = SEG_9;
            default: seg_c = SEG_BLANK;
         endcase
      end
   end

endmodule

// File: rtl/zjh_bcd_counter_disp.sv
// Multi-digit BCD up/down counter with load, compare (reload / stop modes)
// and a time-multiplexed 7-segment display scanner.
//   Clk   : clock, rising edge
//   MR    : asynchronous active-low reset
//   EN    : count enable          UP   : 1 up, 0 down
//   LD    : synchronous load of A MODE : 00 free, 01 reload-on-match, 10 stop-on-match
//   A     : preset BCD            B    : compare BCD
//   LZB   : leading-zero blanking
//   Q     : registered BCD count  MATCH: one-cycle pulse when Q changes to B
//   DONE  : stop-on-match flag    SEG  : segments of the scanned digit
//   DIG   : one-hot digit select
module zjh_bcd_counter_disp
   import zjh_seg_pkg::*;
#(
   parameter int unsigned DIGITS   = 2,
   parameter int unsigned SCAN_DIV = 1000
)(
   input  logic                  Clk,
   input  logic                  MR,
   input  logic                  EN,
   input  logic                  UP,
   input  logic                  LD,
   input  logic [4*DIGITS-1:0]   A,
   input  logic [4*DIGITS-1:0]   B,
   input  logic [1:0]            MODE,
   input  logic                  LZB,
   output logic [4*DIGITS-1:0]   Q,
   output logic                  MATCH,
   output logic                  DONE,
   output logic [6:0]            SEG,
   output logic [DIGITS-1:0]     DIG
);

   localparam int unsigned W  = 4 * DIGITS;
   localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam int unsigned DW = $clog2(SCAN_DIV);

   logic [W-1:0]      q_r, q_n, q_inc, q_dec, a_clean;
   logic              match_r, done_r, done_n, hit;
   logic [DW-1:0]     div_r;
   logic [IW-1:0]     idx_r;
   logic [DIGITS-1:0] dig_r, dig_n;
   seg_t              seg_r, seg_c;
   logic [3:0]        cur_digit;
   logic              upper_zero, cur_upper_zero, blank;

   // Preset with out-of-range digits forced to zero.
   always_comb begin
      a_clean = A;
      for (int i = 0; i < int'(DIGITS); i++) begin
         if (A[i*4 +: 4] > 4'd9) a_clean[i*4 +: 4] = 4'd0;
      end
   end

   // Decimal increment/decrement with ripple carry/borrow across digits.
   always_comb begin : incdec
      logic cy, bw;
      q_inc = q_r;
      q_dec = q_r;
      cy    = 1'b1;
      bw    = 1'b1;
      for (int i = 0; i < int'(DIGITS); i++) begin
         if (cy) begin
            if (q_r[i*4 +: 4] == 4'd9) begin
               q_inc[i*4 +: 4] = 4'd0;
            end else begin
               q_inc[i*4 +: 4] = q_r[i*4 +: 4] + 4'd1;
               cy = 1'b0;
            end
         end
         if (bw) begin
            if (q_r[i*4 +: 4] == 4'd0) begin
               q_dec[i*4 +: 4] = 4'd9;
            end else begin
               q_dec[i*4 +: 4] = q_r[i*4 +: 4] - 4'd1;
               bw = 1'b0;
            end
         end
      end
   end

   // Next count: LD > DONE hold > match reload > count > hold.
   // A load clears DONE and never sets it, even if it lands on B.
   always_comb begin
      q_n    = q_r;
      done_n = done_r;
      if (LD) begin
         q_n    = a_clean;
         done_n = 1'b0;
      end else if (!done_r) begin
         if ((MODE == MODE_RELOAD) && EN && (q_r == B)) q_n = a_clean;
         else if (EN)                                   q_n = UP ? q_inc : q_dec;
      end
      // Only a change of Q onto B counts as a match; a static Q==B does not.
      hit = (q_n != q_r) && (q_n == B);
      if (!LD && !done_r && (MODE == MODE_STOP) && hit) done_n = 1'b1;
   end

   always_ff @(posedge Clk or negedge MR) begin
      if (!MR) begin
         q_r     <= '0;
         match_r <= 1'b0;
         done_r  <= 1'b0;
      end else begin
         q_r     <= q_n;
         match_r <= hit;
         done_r  <= done_n;
      end
   end

   // Select scanned digit, find whether it and all higher digits are zero.
   always_comb begin
      cur_digit      = 4'd0;
      upper_zero     = 1'b1;
      cur_upper_zero = 1'b0;
      dig_n          = '0;
      for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
         upper_zero = upper_zero & (q_r[i*4 +: 4] == 4'd0);
         if (IW'(i) == idx_r) begin
            cur_digit      = q_r[i*4 +: 4];
            cur_upper_zero = upper_zero;
         end
         dig_n[i] = (IW'(i) == idx_r);
      end
      blank = LZB && (idx_r != '0) && cur_upper_zero;
   end

   zjh_seg7_dec u_dec (
      .bcd   (cur_digit),
      .blank (blank),
      .seg_c (seg_c)
   );

   // Scan divider and digit index; DIG/SEG lag the index by one cycle.
   always_ff @(posedge Clk or negedge MR) begin
      if (!MR) begin
         div_r <= '0;
         idx_r <= '0;
         dig_r <= DIGITS'(1);
         seg_r <= SEG_0;
      end else begin
         if (div_r == DW'(SCAN_DIV - 1)) begin
            div_r <= '0;
            idx_r <= (idx_r == IW'(DIGITS - 1)) ? '0 : idx_r + IW'(1);
         end else begin
            div_r <= div_r + DW'(1);
         end
         dig_r <= dig_n;
         seg_r <= seg_c;
      end
   end

   assign Q     = q_r;
   assign MATCH = match_r;
   assign DONE  = done_r;
   assign SEG   = seg_r;
   assign DIG   = dig_r;

endmodule

// File: tb/tb_zjh_bcd_counter_disp.sv
// Self-checking bench for zjh_bcd_counter_disp (DIGITS=2, SCAN_DIV=4).
// Keeps the count as a plain integer 0..99 and the scan position as a
// function of edges since reset; compares every cycle plus directed literals.
module tb_zjh_bcd_counter_disp;

   localparam int unsigned DIGITS   = 2;
   localparam int unsigned SCAN_DIV = 4;

   logic       Clk = 1'b0;
   logic       MR, EN, UP, LD, LZB;
   logic [7:0] A, B, Q;
   logic [1:0] MODE;
   logic       MATCH, DONE;
   logic [6:0] SEG;
   logic [1:0] DIG;

   always #5 Clk = ~Clk;

   zjh_bcd_counter_disp #(.DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV)) dut (
      .Clk(Clk), .MR(MR), .EN(EN), .UP(UP), .LD(LD), .A(A), .B(B),
      .MODE(MODE), .LZB(LZB), .Q(Q), .MATCH(MATCH), .DONE(DONE),
      .SEG(SEG), .DIG(DIG)
   );

   int total  = 0;
   int passed = 0;

   int pat [0:9] = '{32'h7E, 32'h30, 32'h6D, 32'h79, 32'h33,
                     32'h5B, 32'h5F, 32'h70, 32'h7F, 32'h7B};

   // Reference state: count as integer, flags, edges since reset.
   int         mq, k;
   bit         mdone, mmatch;
   logic [6:0] mseg;
   logic [1:0] mdig;

   function automatic logic [7:0] to_bcd(int v);
      return 8'(((v / 10) % 10) * 16 + (v % 10));
   endfunction

   function automatic int clean(logic [7:0] a);
      int hi, lo;
      hi = (a[7:4] > 4'd9) ? 0 : int'(a[7:4]);
      lo = (a[3:0] > 4'd9) ? 0 : int'(a[3:0]);
      return hi * 10 + lo;
   endfunction

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   task automatic model_reset();
      mq = 0; k = 0; mdone = 0; mmatch = 0;
      mseg = 7'h7E; mdig = 2'b01;
   endtask

   // One rising edge of the reference, using the inputs seen at that edge.
   task automatic model_edge();
      int  old_q, idx, dval;
      bit  old_done;
      old_q    = mq;
      old_done = mdone;
      idx      = (k / int'(SCAN_DIV)) % int'(DIGITS);
      dval     = (idx == 0) ? (mq % 10) : (mq / 10);
      mdig     = 2'(1 << idx);
      mseg     = (LZB && idx == 1 && (mq / 10) == 0) ? 7'h00 : 7'(pat[dval]);
      k++;
      if (LD) begin
         mq    = clean(A);
         mdone = 0;
      end else if (!old_done) begin
         if (MODE == 2'b01 && EN && to_bcd(mq) == B) mq = clean(A);
         else if (EN) mq = UP ? (mq + 1) % 100 : (mq + 99) % 100;
      end
      mmatch = (mq != old_q) && (to_bcd(mq) == B);
      if (!LD && !old_done && MODE == 2'b10 && mmatch) mdone = 1;
   endtask

   task automatic compare();
      chk("q",     32'(Q),     32'(to_bcd(mq)));
      chk("match", 32'(MATCH), 32'(mmatch));
      chk("done",  32'(DONE),  32'(mdone));
      chk("seg",   32'(SEG),   32'(mseg));
      chk("dig",   32'(DIG),   32'(mdig));
   endtask

   task automatic step();
      @(posedge Clk);
      model_edge();
      @(negedge Clk);
      compare();
   endtask

   // Asynchronous reset pulse between clock edges, checked before any edge.
   task automatic async_reset(string tag);
      #2 MR = 1'b0;
      #1;
      chk({tag, "_q"},     32'(Q),     32'h00);
      chk({tag, "_dig"},   32'(DIG),   32'h01);
      chk({tag, "_seg"},   32'(SEG),   32'h7E);
      chk({tag, "_match"}, 32'(MATCH), 32'h0);
      chk({tag, "_done"},  32'(DONE),  32'h0);
      model_reset();
      @(negedge Clk);
      MR = 1'b1;
   endtask

   initial begin
      logic [7:0] exp034 [0:2];
      int n01;
      exp034 = '{8'h99, 8'h00, 8'h01};

      MR = 1'b0; EN = 1'b0; UP = 1'b1; LD = 1'b0; A = '0; B = '0;
      MODE = 2'b00; LZB = 1'b0;
      model_reset();
      #12;
      chk("rst_q",   32'(Q),     32'h00);
      chk("rst_dig", 32'(DIG),   32'h01);
      chk("rst_seg", 32'(SEG),   32'h7E);
      chk("rst_m",   32'(MATCH), 32'h0);
      chk("rst_d",   32'(DONE),  32'h0);
      @(negedge Clk);
      MR = 1'b1;

      // Up count through 99 -> 00 wrap.
      A = 8'h98; B = 8'h55; LD = 1'b1; step();
      chk("ld98", 32'(Q), 32'h98);
      LD = 1'b0; EN = 1'b1; UP = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("up_q", 32'(Q), 32'(exp034[i]));
         chk("up_match", 32'(MATCH), 32'h0);
      end

      // Down wrap and invalid-digit load.
      A = 8'h00; LD = 1'b1; EN = 1'b0; step();
      LD = 1'b0; UP = 1'b0; EN = 1'b1; step();
      chk("down_wrap", 32'(Q), 32'h99);
      EN = 1'b0; A = 8'h3C; LD = 1'b1; step();
      chk("ld_invalid", 32'(Q), 32'h30);
      LD = 1'b0;

      // Reload-on-match.
      MODE = 2'b01; A = 8'h10; B = 8'h12; LD = 1'b1; step();
      chk("rl_ld", 32'(Q), 32'h10);
      LD = 1'b0; EN = 1'b1; UP = 1'b1;
      step(); chk("rl_11", 32'(Q), 32'h11); chk("rl_m0", 32'(MATCH), 32'h0);
      step(); chk("rl_12", 32'(Q), 32'h12); chk("rl_m1", 32'(MATCH), 32'h1);
      step(); chk("rl_10", 32'(Q), 32'h10); chk("rl_m2", 32'(MATCH), 32'h0);
      step(); chk("rl_11b", 32'(Q), 32'h11);

      // Stop-on-match.
      MODE = 2'b10; B = 8'h05; A = 8'h00; LD = 1'b1; EN = 1'b0; step();
      LD = 1'b0; EN = 1'b1;
      repeat (4) step();
      step();
      chk("st_q", 32'(Q), 32'h05); chk("st_done", 32'(DONE), 32'h1);
      chk("st_match", 32'(MATCH), 32'h1);
      step();
      chk("st_hold", 32'(Q), 32'h05); chk("st_done2", 32'(DONE), 32'h1);
      chk("st_match2", 32'(MATCH), 32'h0);
      LD = 1'b1; step();
      chk("st_ld", 32'(Q), 32'h00); chk("st_clr", 32'(DONE), 32'h0);
      LD = 1'b0; step();
      chk("st_resume", 32'(Q), 32'h01);

      // Display scan with leading-zero blanking.
      MODE = 2'b00; EN = 1'b0; A = 8'h07; LD = 1'b1; LZB = 1'b1; step();
      LD = 1'b0; step();
      n01 = 0;
      for (int i = 0; i < 16; i++) begin
         step();
         if (DIG == 2'b01) begin
            n01++;
            chk("lzb_d0", 32'(SEG), 32'h70);
         end else begin
            chk("lzb_d1", 32'(SEG), 32'h00);
         end
      end
      chk("lzb_half", 32'(n01), 32'd8);
      LZB = 1'b0; step();
      for (int i = 0; i < 8; i++) begin
         step();
         if (DIG == 2'b10) chk("nolzb_d1", 32'(SEG), 32'h7E);
         else              chk("nolzb_d0", 32'(SEG), 32'h70);
      end

      // Async reset mid-count at 47.
      A = 8'h46; LD = 1'b1; step();
      LD = 1'b0; EN = 1'b1; UP = 1'b1; step();
      chk("pre_rst", 32'(Q), 32'h47);
      async_reset("mr");
      step();
      chk("post_rst", 32'(Q), 32'h01);

      // Randomized traffic against the reference.
      for (int n = 0; n < 3000; n++) begin
         LD = ($urandom_range(0, 15) == 0);
         EN = ($urandom_range(0, 3) != 0);
         UP = 1'($urandom_range(0, 1));
         A  = 8'($urandom);
         if ($urandom_range(0, 31) == 0) MODE = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 31) == 0) LZB  = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 63) == 0)
            B = ($urandom_range(0, 3) == 0) ? 8'($urandom) : to_bcd($urandom_range(0, 99));
         if ($urandom_range(0, 399) == 0) async_reset("rnd_mr");
         step();
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
